// File: rtl/freq_meas_scheduler.sv
// Round-robin scheduler sharing one period detector across NUM_CH inputs; result valid 1 cycle after stable, held under m_ready backpressure.
// Define FREQ_SEQ_CONFIRM_EN to require 8 cycles of unchanged stable period before capture.
module freq_meas_scheduler #(
   parameter int NUM_CH         = 4,
   parameter int COUNTER_WIDTH  = 18,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic [NUM_CH-1:0]           ch_mask,
   input  logic [NUM_CH-1:0]           sig_in,
   output logic                        det_signal,
   output logic                        det_clr_n,
   input  logic [COUNTER_WIDTH-1:0]    det_period,
   input  logic                        det_stable,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [$clog2(NUM_CH)-1:0]   m_ch,
   output logic [COUNTER_WIDTH-1:0]    m_period,
   output logic                        m_timeout
);

   localparam int CHW = $clog2(NUM_CH);
   localparam int SW  = $clog2(SETTLE_CYCLES);
   localparam int TW  = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      CLEAR,
      WAIT,
      OUTPUT
   } state_t;

   state_t                   state_q, state_d;
   logic [CHW-1:0]           cur_ch_q, cur_ch_d;
   logic [SW-1:0]            settle_q, settle_d;
   logic [TW-1:0]            to_cnt_q, to_cnt_d;
   logic [CHW-1:0]           m_ch_q, m_ch_d;
   logic [COUNTER_WIDTH-1:0] m_period_q, m_period_d;
   logic                     m_timeout_q, m_timeout_d;
   logic                     det_signal_q;

   logic                     pick_found;
   logic [CHW-1:0]           pick_ch;
   logic                     capture_ok;

   // Scan downwards so the last hit is the nearest set bit after cur_ch (i = NUM_CH is cur_ch itself).
   always_comb begin
      pick_found = 1'b0;
      pick_ch    = cur_ch_q;
      for (int i = NUM_CH; i >= 1; i--) begin
         if (ch_mask[CHW'((int'(cur_ch_q) + i) % NUM_CH)]) begin
            pick_found = 1'b1;
            pick_ch    = CHW'((int'(cur_ch_q) + i) % NUM_CH);
         end
      end
   end

`ifdef FREQ_SEQ_CONFIRM_EN
   logic [3:0]               conf_cnt_q, conf_cnt_d;
   logic [COUNTER_WIDTH-1:0] conf_per_q, conf_per_d;
   logic                     conf_same;

   always_comb begin
      conf_cnt_d = '0;
      conf_per_d = conf_per_q;
      conf_same  = (conf_cnt_q == 4'd0) || (det_period == conf_per_q);
      capture_ok = 1'b0;
      if (state_q == WAIT) begin
         if (!det_stable) begin
            conf_cnt_d = '0;
         end else if (!conf_same) begin
            conf_cnt_d = 4'd1;
            conf_per_d = det_period;
         end else begin
            conf_per_d = det_period;
            conf_cnt_d = (conf_cnt_q == 4'd8) ? conf_cnt_q : conf_cnt_q + 4'd1;
            capture_ok = (conf_cnt_q == 4'd8);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conf_cnt_q <= '0;
         conf_per_q <= '0;
      end else begin
         conf_cnt_q <= conf_cnt_d;
         conf_per_q <= conf_per_d;
      end
   end
`else
   assign capture_ok = det_stable;
`endif

   always_comb begin
      state_d     = state_q;
      cur_ch_d    = cur_ch_q;
      settle_d    = settle_q;
      to_cnt_d    = to_cnt_q;
      m_ch_d      = m_ch_q;
      m_period_d  = m_period_q;
      m_timeout_d = m_timeout_q;
      det_clr_n   = 1'b0;
      m_valid     = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable && (|ch_mask)) state_d = SELECT;
         end
         SELECT: begin
            if (!enable || !pick_found) begin
               state_d = IDLE;
            end else begin
               cur_ch_d = pick_ch;
               settle_d = '0;
               state_d  = CLEAR;
            end
         end
         CLEAR: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
               to_cnt_d = '0;
               state_d  = WAIT;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         WAIT: begin
            det_clr_n = 1'b1;
            if (!enable) begin
               state_d = IDLE;
            end else if (capture_ok) begin
               m_ch_d      = cur_ch_q;
               m_period_d  = det_period;
               m_timeout_d = 1'b0;
               state_d     = OUTPUT;
            end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               m_ch_d      = cur_ch_q;
               m_period_d  = '0;
               m_timeout_d = 1'b1;
               state_d     = OUTPUT;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         OUTPUT: begin
            m_valid = 1'b1;
            if (m_ready) state_d = enable ? SELECT : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cur_ch_q     <= CHW'(NUM_CH - 1);
         settle_q     <= '0;
         to_cnt_q     <= '0;
         m_ch_q       <= '0;
         m_period_q   <= '0;
         m_timeout_q  <= 1'b0;
         det_signal_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_ch_q     <= cur_ch_d;
         settle_q     <= settle_d;
         to_cnt_q     <= to_cnt_d;
         m_ch_q       <= m_ch_d;
         m_period_q   <= m_period_d;
         m_timeout_q  <= m_timeout_d;
         det_signal_q <= sig_in[cur_ch_q];
      end
   end

   assign det_signal = det_signal_q;
   assign m_ch       = m_ch_q;
   assign m_period   = m_period_q;
   assign m_timeout  = m_timeout_q;

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Bench for freq_meas_scheduler: detector model plus expectation queue checked by an independent output monitor.
module tb_freq_meas_scheduler;

   localparam int NUM_CH = 4;
   localparam int CW     = 18;
   localparam int SETTLE = 16;
   localparam int TMO    = 1000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [3:0]    ch_mask;
   logic [3:0]    sig_in;
   logic          det_signal;
   logic          det_clr_n;
   logic [CW-1:0] det_period;
   logic          det_stable;
   logic          m_valid;
   logic          m_ready;
   logic [1:0]    m_ch;
   logic [CW-1:0] m_period;
   logic          m_timeout;

   freq_meas_scheduler #(
      .NUM_CH(NUM_CH), .COUNTER_WIDTH(CW), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask), .sig_in(sig_in),
      .det_signal(det_signal), .det_clr_n(det_clr_n), .det_period(det_period),
      .det_stable(det_stable), .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch),
      .m_period(m_period), .m_timeout(m_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int period;
      int tmo;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   n_pop = 0;
   int   last_pop_ch = -1;
   int   fixed_d = -1;
   int   fixed_p = -1;
   int   last_entry = -1;
   int   model_last = NUM_CH - 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int next_ch(input int last, input logic [3:0] mask);
      for (int i = 1; i <= NUM_CH; i++)
         if (mask[(last + i) % NUM_CH]) return (last + i) % NUM_CH;
      return -1;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Detector model: clears while det_clr_n is low, goes stable after a chosen delay, predicts the result.
   initial begin
      int   wcnt;
      int   cur_d;
      int   cur_p;
      int   mch;
      bit   in_wait;
      exp_t e;
      wcnt = 0; cur_d = 0; cur_p = 0; mch = 0; in_wait = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            model_last = NUM_CH - 1;
            in_wait    = 0;
            det_stable = 1'b0;
            det_period = '0;
         end else begin
            if (det_clr_n && !in_wait) begin
               in_wait    = 1;
               wcnt       = 0;
               last_entry = cyc;
               mch        = next_ch(model_last, ch_mask);
               model_last = mch;
               if (fixed_d >= 0) cur_d = fixed_d;
               else cur_d = ($urandom % 8 == 0) ? 1500 : int'($urandom % 60);
               cur_p = (fixed_p >= 0) ? fixed_p : int'($urandom_range(1, 262143));
            end else if (det_clr_n) begin
               wcnt++;
            end else begin
               in_wait = 0;
            end
            det_stable = 1'b0;
            det_period = CW'($urandom);
            if (det_clr_n) begin
               chk("det_signal", 32'(det_signal), 32'(sig_in[mch]));
               if (wcnt == cur_d && cur_d < TMO) begin
                  det_stable = 1'b1;
                  det_period = CW'(cur_p);
                  e = '{ch: mch, period: cur_p, tmo: 0, cyc: cyc + 1};
                  if (enable) exp_q.push_back(e);
               end else if (wcnt == TMO - 1) begin
                  e = '{ch: mch, period: 0, tmo: 1, cyc: cyc + 1};
                  if (enable) exp_q.push_back(e);
               end
            end
            sig_in = 4'($urandom);
         end
      end
   end

   // Output monitor: every valid cycle must match the head expectation; pop on transfer.
   initial begin
      bit   prev_valid;
      int   rise;
      exp_t e;
      prev_valid = 0;
      rise = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 0;
         end else begin
            if (m_valid) begin
               if (!prev_valid) rise = cyc;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_valid: got m_ch=%0d m_period=%0d, required no result (cycle %0d)",
                           m_ch, m_period, cyc);
               end else begin
                  e = exp_q[0];
                  chk("m_ch", 32'(m_ch), e.ch);
                  chk("m_period", 32'(m_period), e.period);
                  chk("m_timeout", 32'(m_timeout), e.tmo);
                  chk("clr_in_output", 32'(det_clr_n), 0);
                  if (m_ready) begin
                     chk("result_latency", rise, e.cyc);
                     void'(exp_q.pop_front());
                     last_pop_ch = e.ch;
                     n_pop++;
                  end
               end
            end
            prev_valid = m_valid;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_results(input int n, input int budget, input bit rand_ready);
      int target;
      int k;
      target = n_pop + n;
      k = 0;
      while (n_pop < target && k < budget) begin
         if (rand_ready) m_ready = ($urandom % 3 != 0);
         tick();
         k++;
      end
      if (n_pop < target) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_results: got %0d results, required %0d", n_pop - target + n, n);
      end
   endtask

   task automatic stop_run();
      int k;
      int p0;
      int hi;
      m_ready = 1'b1;
      k = 0;
      while (!m_valid && k < 3000) begin
         tick();
         k++;
      end
      chk("stop_sees_valid", 32'(m_valid), 1);
      p0 = n_pop;
      enable = 1'b0;
      repeat (3) tick();
      chk("drain_handshake", n_pop, p0 + 1);
      hi = 0;
      repeat (30) begin
         tick();
         if (det_clr_n || m_valid) hi++;
      end
      chk("idle_after_disable", hi, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_m_valid"}, 32'(m_valid), 0);
      chk({tag, "_m_ch"}, 32'(m_ch), 0);
      chk({tag, "_m_period"}, 32'(m_period), 0);
      chk({tag, "_m_timeout"}, 32'(m_timeout), 0);
      chk({tag, "_det_clr_n"}, 32'(det_clr_n), 0);
      chk({tag, "_det_signal"}, 32'(det_signal), 0);
   endtask

   initial begin
      int c0;
      int k;
      int p0;
      int hi;
      rst_n = 1'b0; enable = 1'b0; ch_mask = '0; m_ready = 1'b0;
      sig_in = '0; det_stable = 1'b0; det_period = '0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Single channel, fixed period, first WAIT entry timing from enable.
      ch_mask = 4'b0001; fixed_d = 50; fixed_p = 2000; m_ready = 1'b1;
      last_entry = -1;
      enable = 1'b1;
      c0 = cyc;
      k = 0;
      while (last_entry < 0 && k < 200) begin tick(); k++; end
      chk("first_wait_entry_cycle", last_entry, c0 + 2 + SETTLE);
      wait_results(4, 2000, 0);
      stop_run();

      // Round robin over a sparse mask with immediate stable.
      ch_mask = 4'b1011; fixed_d = 0; fixed_p = -1;
      enable = 1'b1;
      wait_results(6, 1000, 0);
      stop_run();

      // Long backpressure, single transfer, then async reset while a result is pending.
      ch_mask = 4'b0010; fixed_d = 5; m_ready = 1'b0;
      enable = 1'b1;
      k = 0;
      while (!m_valid && k < 500) begin tick(); k++; end
      chk("bp_valid_seen", 32'(m_valid), 1);
      p0 = n_pop;
      hi = 0;
      repeat (100) begin
         tick();
         if (!m_valid) hi++;
      end
      chk("bp_valid_held", hi, 0);
      chk("bp_no_transfer", n_pop, p0);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("bp_single_transfer", n_pop, p0 + 1);
      chk("bp_valid_dropped", 32'(m_valid), 0);
      k = 0;
      while (!m_valid && k < 500) begin tick(); k++; end
      chk("pre_reset_valid", 32'(m_valid), 1);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      ch_mask = 4'b1011; fixed_d = 3; m_ready = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      wait_results(1, 500, 0);
      chk("first_after_reset_ch", last_pop_ch, 0);
      stop_run();

      // Timeout, then stable coinciding with the last timeout cycle.
      ch_mask = 4'b0100; fixed_d = 5000;
      enable = 1'b1;
      wait_results(1, 3000, 0);
      fixed_d = TMO - 1;
      wait_results(1, 3000, 0);
      stop_run();

      // Enable dropped during WAIT: no result, IDLE next cycle.
      ch_mask = 4'b0001; fixed_d = 500;
      enable = 1'b1;
      k = 0;
      while (!det_clr_n && k < 200) begin tick(); k++; end
      chk("wait_reached", 32'(det_clr_n), 1);
      repeat (10) tick();
      enable = 1'b0;
      tick();
      chk("wait_drop_clr", 32'(det_clr_n), 0);
      hi = 0;
      repeat (50) begin
         tick();
         if (det_clr_n || m_valid) hi++;
      end
      chk("wait_drop_idle", hi, 0);

      // Empty mask keeps the scheduler idle.
      ch_mask = 4'b0000;
      enable = 1'b1;
      hi = 0;
      repeat (50) begin
         tick();
         if (det_clr_n || m_valid) hi++;
      end
      chk("zero_mask_idle", hi, 0);
      enable = 1'b0;
      tick();

      // Randomised masks, delays, periods and ready.
      fixed_d = -1; fixed_p = -1;
      for (int seg = 0; seg < 3; seg++) begin
         ch_mask = 4'($urandom_range(1, 15));
         enable = 1'b1;
         wait_results(12, 20000, 1);
         stop_run();
      end

      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish within the cycle limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/freq_meas_scheduler.md
# freq_meas_scheduler

Round-robin measurement scheduler that shares one square-wave period detector among `NUM_CH` comparator inputs. It sits between the comparator pins and the period detector, which exposes `period`/`stable` outputs and uses synchronous-clear semantics. Per channel it routes the input, clears the detector and waits for a stable period or a timeout. It then hands the result downstream over a valid/ready interface.

## Interface
- `NUM_CH`, 4 — number of square-wave inputs (2..16).
- `COUNTER_WIDTH`, 18 — period width; matches detector.
- `SETTLE_CYCLES`, 16 — cycles `det_clr_n` held low after a channel switch (≥2).
- `TIMEOUT_CYCLES`, 2_000_000 — max `WAIT` cycles before giving up (10 ms at 200 MHz).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  run scheduling.
- `ch_mask`  in  `NUM_CH`  1 = channel participates; sampled only in `SELECT`.
- `sig_in`  in  `NUM_CH`  raw comparator outputs.
- `det_signal`  out  1  selected channel, to detector `signal_in`.
- `det_clr_n`  out  1  synchronous clear to detector, active-low.
- `det_period`  in  `COUNTER_WIDTH`  detector period.
- `det_stable`  in  1  detector stable flag.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  consumer accepts.
- `m_ch`  out  `$clog2(NUM_CH)`  channel of result.
- `m_period`  out  `COUNTER_WIDTH`  measured period; 0 on timeout.
- `m_timeout`  out  1  result is a timeout.

## Operation
- FSM states: `IDLE`, `SELECT`, `CLEAR`, `WAIT`, `OUTPUT`.
- **`IDLE`**
  - `det_clr_n` = 0.
  - Goes to `SELECT` when `enable`=1 and `ch_mask`≠0.
- **`SELECT`** (1 cycle)
  - Picks the first set bit of `ch_mask` strictly after `cur_ch`, wrapping modulo `NUM_CH`.
  - A single-bit mask reselects the same channel.
  - Mask = 0 → `IDLE`.
  - Otherwise latches `cur_ch` → `CLEAR`.
- **`CLEAR`**
  - `det_clr_n` = 0 for `SETTLE_CYCLES` cycles, then → `WAIT`.
  - The timeout counter is zeroed on entry to `WAIT`.
- **`WAIT`**
  - `det_clr_n` = 1.
  - `det_stable` = 1 → latch `m_period`=`det_period`, `m_timeout`=0 → `OUTPUT`.
  - Counter reaching `TIMEOUT_CYCLES-1` → `m_period`=0, `m_timeout`=1 → `OUTPUT`.
  - If stable and timeout coincide, stable wins.
- **`OUTPUT`**
  - `m_valid` = 1 and `m_ch`=`cur_ch`; data held constant until `m_valid && m_ready`.
  - Then → `SELECT`, or `IDLE` if `enable`=0.
  - `det_clr_n` = 0 throughout.
- `enable` falling in `SELECT`/`CLEAR`/`WAIT` → `IDLE` next cycle; no result is emitted.
- `enable` falling in `OUTPUT` → the pending result completes its handshake first.
- `det_signal` = registered `sig_in[cur_ch]`. Channel switching occurs only while `det_clr_n`=0, so glitches are absorbed by the clear.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES)`; it saturates and never wraps.

## Timing
- Reset values:
  - state `IDLE`, `cur_ch`=`NUM_CH-1` (so the first pick is ch0 when enabled).
  - `det_clr_n`=0, `det_signal`=0.
  - `m_valid`=0, `m_ch`=0, `m_period`=0, `m_timeout`=0.
- Latency:
  - `enable` rise at cycle N (`IDLE`) → `SELECT` at N+1 → `CLEAR` N+2..N+1+`SETTLE_CYCLES` → `WAIT`.
  - `det_stable` sampled high at cycle W → `m_valid`=1 at W+1.
  - Handshake at cycle H → `m_valid`=0 at H+1, `SELECT` at H+1.
- `m_ready` may be high before `m_valid`; transfer occurs on the first cycle both are high.
- `rst_n` asserted mid-operation → all outputs return to reset values immediately (async); the current result is lost.

## Configuration
- `FREQ_SEQ_CONFIRM_EN` defined:
  - In `WAIT`, capture requires `det_stable`=1 and an unchanged `det_period` for 8 consecutive cycles.
  - Any change or stable drop restarts the 8-cycle confirmation.
  - Each `WAIT` entry adds 8 cycles minimum latency.
- Undefined: capture occurs on the first `WAIT` cycle with `det_stable`=1.

## Test plan
- **Single channel:** mask=4'b0001, `SETTLE_CYCLES`=16, detector model asserts stable with period 2000 after 50 `WAIT` cycles, `m_ready`=1 → `m_valid` pulses once per round with `m_ch`=0, `m_period`=2000, `m_timeout`=0; each result arrives 1 cycle after stable.
- **Round robin:** mask=4'b1011, stable immediately → result sequence `m_ch` = 0,1,3,0,1,3.
- **Backpressure:** `m_ready`=0 for 100 cycles while `m_valid`=1 → `m_period`/`m_ch` held constant, `det_clr_n`=0; `m_ready`=1 → single transfer, then `SELECT`.
- **Timeout:** `TIMEOUT_CYCLES`=1000, `det_stable` never high → `m_timeout`=1, `m_period`=0 exactly 1000 cycles after `WAIT` entry. Stable and timeout in the same cycle → `m_timeout`=0.
- **Enable/mask edges:**
  - `enable` drops in `WAIT` → `IDLE` next cycle, no `m_valid`.
  - `enable` drops in `OUTPUT` → handshake completes, then `IDLE`.
  - mask=0 → stays `IDLE`.
- **Reset mid-`OUTPUT`:** all outputs return to reset values asynchronously. After release with `enable`=1, the first result has `m_ch`=0.
